// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
// Holds the access-type encodings, exception codes, the byte/half/word
// field widths, the registered-request record and the store-side lane
// helpers (misalignment test, byte enables, write-data steering).
package load_store_unit_pkg;

  // Access types presented on req_type
  localparam logic [2:0] LSU_T_WORD = 3'b000;
  localparam logic [2:0] LSU_T_RSVD = 3'b001;  // reserved, behaves as word
  localparam logic [2:0] LSU_T_HS   = 3'b010;
  localparam logic [2:0] LSU_T_HU   = 3'b011;
  localparam logic [2:0] LSU_T_BS   = 3'b100;
  localparam logic [2:0] LSU_T_BU   = 3'b101;
  localparam logic [2:0] LSU_T_WL   = 3'b110;
  localparam logic [2:0] LSU_T_WR   = 3'b111;

  // Exception codes
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_BUS  = 5'd7;

  // Field widths
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  // Request captured on accept
  typedef struct packed {
    logic              we;
    logic [2:0]        typ;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] rt;
    logic [WORD_W-1:0] pc;
  } lsu_req_t;

  // Word accesses need a[1:0]==0, half accesses need a[0]==0
  function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] a);
    logic mis;
    case (t)
      LSU_T_WORD, LSU_T_RSVD: mis = (a != 2'b00);
      LSU_T_HS, LSU_T_HU:     mis = a[0];
      default:                mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte enables for a store (little-endian lanes)
  function automatic logic [3:0] store_be(input logic [2:0] t, input logic [1:0] a);
    logic [3:0] be;
    case (t)
      LSU_T_HS, LSU_T_HU: be = a[1] ? 4'b1100 : 4'b0011;
      LSU_T_BS, LSU_T_BU: be = 4'b0001 << a;
      LSU_T_WL:           be = 4'b1111 >> (2'd3 - a);
      LSU_T_WR:           be = 4'b1111 << a;
      default:            be = 4'b1111;
    endcase
    return be;
  endfunction

  // Write data steered onto the lanes selected by store_be
  function automatic logic [WORD_W-1:0] store_wdata(input logic [2:0] t, input logic [1:0] a,
                                                    input logic [WORD_W-1:0] wd);
    logic [WORD_W-1:0] d;
    case (t)
      LSU_T_HS, LSU_T_HU: d = {2{wd[HALF_W-1:0]}};
      LSU_T_BS, LSU_T_BU: d = {4{wd[BYTE_W-1:0]}};
      LSU_T_WL:           d = wd >> {(2'd3 - a), 3'b000};
      LSU_T_WR:           d = wd << {a, 3'b000};
      default:            d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_lane_ext.sv
// Load-side lane extraction for the load/store unit (purely combinational).
// Ports:
//   typ  - access type of the captured request
//   a    - byte offset addr[1:0] of the captured request
//   m    - raw word returned by memory
//   rt   - old rt value used by the partial-word merges
//   data - extended or merged load result
module lsu_lane_ext
  import load_store_unit_pkg::*;
(
  input  logic [2:0]        typ,
  input  logic [1:0]        a,
  input  logic [WORD_W-1:0] m,
  input  logic [WORD_W-1:0] rt,
  output logic [WORD_W-1:0] data
);

  logic [HALF_W-1:0] half_s;
  logic [BYTE_W-1:0] byte_s;

  // Pick the addressed half and byte lanes
  always_comb begin
    half_s = a[1] ? m[31:16] : m[15:0];
    case (a)
      2'd0:    byte_s = m[7:0];
      2'd1:    byte_s = m[15:8];
      2'd2:    byte_s = m[23:16];
      2'd3:    byte_s = m[31:24];
      default: byte_s = m[7:0];
    endcase
  end

  // Extend the picked lane, or merge memory with rt for the unaligned forms
  always_comb begin
    data = m;
    case (typ)
      LSU_T_HS: data = {{HALF_W{half_s[HALF_W-1]}}, half_s};
      LSU_T_HU: data = {{HALF_W{1'b0}}, half_s};
      LSU_T_BS: data = {{(WORD_W-BYTE_W){byte_s[BYTE_W-1]}}, byte_s};
      LSU_T_BU: data = {{(WORD_W-BYTE_W){1'b0}}, byte_s};
      LSU_T_WL: begin
        // memory supplies the high-order bytes, rt keeps the rest
        case (a)
          2'd0:    data = {m[7:0],  rt[23:0]};
          2'd1:    data = {m[15:0], rt[15:0]};
          2'd2:    data = {m[23:0], rt[7:0]};
          default: data = m;
        endcase
      end
      LSU_T_WR: begin
        // memory supplies the low-order bytes, rt keeps the rest
        case (a)
          2'd1:    data = {rt[31:24], m[31:8]};
          2'd2:    data = {rt[31:16], m[31:16]};
          2'd3:    data = {rt[31:8],  m[31:24]};
          default: data = m;
        endcase
      end
      default: data = m;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access from the pipeline, checks alignment,
// performs a single word-aligned memory transaction with a timeout, and
// returns either the extended/merged load data or an exception.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   req_*                       - pipeline request (valid/ready handshake)
//   resp_valid, resp_rdata      - one-cycle completion with load data
//   exc_valid, exc_code,
//   exc_pc, badvaddr            - one-cycle exception report
//   stall                       - high while an access is in flight
//   mem_*                       - word-aligned memory port, held until mem_ack
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic [31:0] badvaddr,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // last ISSUE cycle that may still see mem_ack
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_EXC   = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  lsu_req_t         req_q,       req_d;
  logic             mem_we_q,    mem_we_d;
  logic [31:0]      mem_addr_q,  mem_addr_d;
  logic [3:0]       mem_be_q,    mem_be_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      rdata_q,     rdata_d;
  logic [4:0]       exc_code_q,  exc_code_d;
  logic [31:0]      exc_pc_q,    exc_pc_d;
  logic [31:0]      badvaddr_q,  badvaddr_d;
  logic [31:0]      ext_s;

  lsu_lane_ext u_lane_ext (
    .typ  (req_q.typ),
    .a    (req_q.addr[1:0]),
    .m    (mem_rdata),
    .rt   (req_q.rt),
    .data (ext_s)
  );

  // Next-state, request capture and output-register updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    exc_code_d  = exc_code_q;
    exc_pc_d    = exc_pc_q;
    badvaddr_d  = badvaddr_q;
    case (state_q)
      ST_IDLE: begin
        // req_ready is high throughout IDLE, so valid alone means accept
        if (req_valid) begin
          req_d.we    = req_we;
          req_d.typ   = req_type;
          req_d.addr  = req_addr;
          req_d.rt    = req_rt;
          req_d.pc    = req_pc;
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_be_d    = req_we ? store_be(req_type, req_addr[1:0]) : 4'b1111;
          mem_wdata_d = req_we ? store_wdata(req_type, req_addr[1:0], req_wdata) : 32'h0000_0000;
          cnt_d       = {CNT_W{1'b0}};
          if (is_misaligned(req_type, req_addr[1:0])) begin
            state_d    = ST_EXC;
            exc_code_d = req_we ? EXC_ADES : EXC_ADEL;
            exc_pc_d   = req_pc;
            badvaddr_d = req_addr;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // an ack on the final counted cycle still wins over the timeout
        if (mem_ack) begin
          state_d = ST_RESP;
          rdata_d = req_q.we ? 32'h0000_0000 : ext_s;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_EXC;
          exc_code_d = EXC_BUS;
          exc_pc_d   = req_q.pc;
          badvaddr_d = req_q.addr;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_EXC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      req_q       <= {$bits(lsu_req_t){1'b0}};
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      exc_code_q  <= 5'd0;
      exc_pc_q    <= 32'h0000_0000;
      badvaddr_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      exc_code_q  <= exc_code_d;
      exc_pc_q    <= exc_pc_d;
      badvaddr_q  <= badvaddr_d;
    end
  end

  // Handshake and strobes decode directly from the state register
  assign req_ready  = (state_q == ST_IDLE);
  assign stall      = (state_q != ST_IDLE);
  assign mem_req    = (state_q == ST_ISSUE);
  assign resp_valid = (state_q == ST_RESP);
  assign exc_valid  = (state_q == ST_EXC);

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = rdata_q;
  assign exc_code   = exc_code_q;
  assign exc_pc     = exc_pc_q;
  assign badvaddr   = badvaddr_q;

endmodule
